// File: rtl/ibuf_if.sv
// Shared width package and the fetch/decode handshake bundle of the instruction buffer.
package params_pkg;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
endpackage

interface ibuf_if #(
  parameter int unsigned ADDR_W  = params_pkg::ADDR_W,
  parameter int unsigned INSTR_W = params_pkg::INSTR_W
);
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic [ADDR_W-1:0]  in_pc;
  logic               hold;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_ready;

  // master is the environment (fetch + decode side), slave is the buffer
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  hold, out_valid, out_instr, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output hold, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/ibuf.sv
// Instruction buffer between fetch and decode: first-word-fall-through circular FIFO
// with fetch backpressure (hold), flush, and a sticky overflow flag for dropped fetches.
module ibuf #(
  parameter int unsigned ADDR_W  = params_pkg::ADDR_W,
  parameter int unsigned INSTR_W = params_pkg::INSTR_W,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  ibuf_if.slave                      bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("ibuf: DEPTH must be a power of two and at least 2");
  end

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic not_empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    not_empty = (count != '0);
    full      = (count == CNT_W'(DEPTH));
    pop       = not_empty & bus.out_ready;
    // a full buffer can still take the offer when the head leaves this cycle
    push      = bus.in_valid & (!full | pop);
    drop      = bus.in_valid & full & !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      instr_mem[wr_ptr] <= bus.in_instr;
      pc_mem[wr_ptr]    <= bus.in_pc;
    end
  end

  always_comb begin
    bus.out_valid = not_empty;
    bus.out_instr = not_empty ? instr_mem[rd_ptr] : '0;
    bus.out_pc    = not_empty ? pc_mem[rd_ptr]    : '0;
    // one spare slot absorbs the fetch already in flight when hold rises
    bus.hold      = (count >= CNT_W'(DEPTH - 1));
  end

endmodule

// File: tb/tb_ibuf.sv
// Self-checking bench for ibuf: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_ibuf;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       overflow;

  ibuf_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  ibuf #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bus     (bus),
    .count   (count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t m_q[$];
  logic   m_ovf;
  int     checks;
  int     failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: a plain queue; rst empties and clears the flag, flush empties only
  task automatic model_update(input logic r, input logic f, input logic v,
                              input logic [31:0] instr, input logic [31:0] pc,
                              input logic rdy);
    entry_t e;
    if (r) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else if (f) begin
      m_q.delete();
    end else begin
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (v) begin
        if (m_q.size() < DEPTH) begin
          e.instr = instr;
          e.pc    = pc;
          m_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic compare();
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    exp_instr = (m_q.size() > 0) ? m_q[0].instr : 32'h0;
    exp_pc    = (m_q.size() > 0) ? m_q[0].pc    : 32'h0;
    chk("model_out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
    chk("model_out_instr", bus.out_instr, exp_instr);
    chk("model_out_pc",    bus.out_pc,    exp_pc);
    chk("model_count",     32'(count),    32'(m_q.size()));
    chk("model_hold",      32'(bus.hold), 32'(m_q.size() >= DEPTH - 1));
    chk("model_overflow",  32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(input logic r, input logic f, input logic v,
                      input logic [31:0] instr, input logic [31:0] pc, input logic rdy);
    rst           = r;
    flush         = f;
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    @(posedge clk);
    model_update(r, f, v, instr, pc, rdy);
    @(negedge clk);
    compare();
  endtask

  logic [31:0] drain_exp [4];

  initial begin
    checks   = 0;
    failures = 0;
    m_ovf    = 1'b0;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;

    // reset held two cycles with traffic offered
    step(1, 0, 1, 32'hDEADBEEF, 32'h40, 1);
    step(1, 0, 1, 32'hDEADBEEF, 32'h44, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_hold", 32'(bus.hold), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // fill without consuming
    step(0, 0, 1, 32'h11111111, 32'h00, 0);
    chk("fill1_valid", 32'(bus.out_valid), 1);
    chk("fill1_instr", bus.out_instr, 32'h11111111);
    chk("fill1_pc", bus.out_pc, 32'h00);
    chk("fill1_hold", 32'(bus.hold), 0);
    step(0, 0, 1, 32'h22222222, 32'h04, 0);
    step(0, 0, 1, 32'h33333333, 32'h08, 0);
    chk("fill3_count", 32'(count), 3);
    chk("fill3_hold", 32'(bus.hold), 1);
    step(0, 0, 1, 32'h44444444, 32'h0C, 0);
    chk("fill4_count", 32'(count), 4);

    // overflow on full, then push-with-pop on full
    step(0, 0, 1, 32'h55555555, 32'h10, 0);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head", bus.out_instr, 32'h11111111);
    step(0, 0, 1, 32'h66666666, 32'h14, 1);
    chk("fullpp_count", 32'(count), 4);
    chk("fullpp_head", bus.out_instr, 32'h22222222);
    drain_exp[0] = 32'h22222222; drain_exp[1] = 32'h33333333;
    drain_exp[2] = 32'h44444444; drain_exp[3] = 32'h66666666;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0d", i), bus.out_instr, drain_exp[i]);
      step(0, 0, 0, 32'h0, 32'h0, 1);
    end
    chk("drain_empty", 32'(bus.out_valid), 0);
    // empty with out_ready: nothing moves
    step(0, 0, 0, 32'h0, 32'h0, 1);
    chk("empty_rdy_count", 32'(count), 0);

    // flush priority over push and pop; overflow survives the flush
    step(0, 0, 1, 32'hC0000001, 32'h100, 0);
    step(0, 0, 1, 32'hC0000002, 32'h104, 0);
    step(0, 0, 1, 32'hC0000003, 32'h108, 0);
    chk("preflush_count", 32'(count), 3);
    step(0, 1, 1, 32'h77777777, 32'h10C, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(bus.out_valid), 0);
    chk("flush_hold", 32'(bus.hold), 0);
    chk("flush_keeps_ovf", 32'(overflow), 1);
    step(0, 0, 1, 32'h88888888, 32'h110, 0);
    chk("postflush_head", bus.out_instr, 32'h88888888);
    chk("postflush_pc", bus.out_pc, 32'h110);

    // reset mid-operation
    step(0, 0, 1, 32'h99999999, 32'h114, 0);
    chk("premid_count", 32'(count), 2);
    step(1, 0, 1, 32'hBAD0BAD0, 32'h118, 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_ovf", 32'(overflow), 0);
    step(0, 0, 1, 32'hABCDEF01, 32'h200, 0);
    chk("postrst_head", bus.out_instr, 32'hABCDEF01);
    chk("postrst_count", 32'(count), 1);
    step(0, 0, 0, 32'h0, 32'h0, 1);

    // streaming with wrap: each push visible one cycle later, count stays at 1
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 32'hA0 + 32'(i), 32'(4 * i), 1);
      chk($sformatf("stream_instr_%0d", i), bus.out_instr, 32'hA0 + 32'(i));
      chk($sformatf("stream_pc_%0d", i), bus.out_pc, 32'(4 * i));
      chk($sformatf("stream_count_%0d", i), 32'(count), 1);
    end
    chk("stream_ovf", 32'(overflow), 0);
    step(0, 0, 0, 32'h0, 32'h0, 1);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic r, f, v, rdy;
      r   = ($urandom_range(0, 199) == 0);
      f   = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 99) < 60);
      rdy = (n % 600 < 300) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 30);
      step(r, f, v, $urandom(), $urandom() & 32'hFFFF_FFFC, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibuf.md
Name: ibuf

Overview:
- Instruction buffer sitting directly downstream of the fetch stage.
- Captures each fetched instruction and its PC while fetch's valid is high, and presents them in order to the decode/issue stage over a valid/ready handshake.
- Drives the hold input of fetch for backpressure.
- Is cleared by the same flush that fetch receives.

Parameters:
- ADDR_W, default params_pkg::ADDR_W: PC/address width.
- INSTR_W, default params_pkg::INSTR_W: instruction width.
- DEPTH, default 4: number of entries. Must be a power of two and ≥ 2.

Ports:
- clk  input  1: system clock. All state updates on its rising edge.
- rst  input  1: synchronous, active-high reset.
- flush  input  1: discard all buffered entries (same signal as fetch flush).
- in_valid  input  1: fetch valid; an instruction is offered this cycle.
- in_instr  input  INSTR_W: fetched instruction.
- in_pc  input  ADDR_W: PC of in_instr (fetch pc_curr).
- hold  output  1: backpressure to fetch hold.
- out_valid  output  1: head entry available.
- out_instr  output  INSTR_W: head instruction.
- out_pc  output  ADDR_W: head PC.
- out_ready  input  1: consumer accepts head this cycle.
- count  output  $clog2(DEPTH+1): number of occupied entries.
- overflow  output  1: sticky flag; an offered instruction was dropped.

Behaviour:
- Implementation:
  - Circular FIFO with wr_ptr, rd_ptr and a registered count.
  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 → 0 naturally.
  - Storage arrays are not reset.
- Reset (rst=1 at a clock edge):
  - count=0, wr_ptr=0, rd_ptr=0, overflow=0.
  - Consequently out_valid=0, hold=0, out_instr='0, out_pc='0.
  - Reset overrides flush, push and pop.
  - Reset asserted mid-operation discards all entries within one cycle.
- Output timing:
  - out_valid = (count != 0).
  - out_instr/out_pc = storage[rd_ptr] when out_valid=1, else forced to '0.
  - Outputs are first-word-fall-through, combinational from registers only.
  - No same-cycle bypass: an entry pushed at edge N is visible on out_* after edge N, i.e. 1-cycle latency.
- pop = out_valid & out_ready. On a pop, rd_ptr is incremented.
- push = in_valid & (count < DEPTH | pop). On a push:
  - in_instr and in_pc are written at wr_ptr.
  - wr_ptr is incremented.
  - Push on a full buffer is permitted only when a pop happens in the same cycle.
- count update:
  - count += push − pop.
  - A simultaneous push and pop leaves count unchanged, including when empty→no pop and when full with pop.
- Drop condition:
  - in_valid & count==DEPTH & !pop: instruction is dropped, overflow ← 1.
  - overflow stays set until rst; flush does not clear it.
- hold = (count ≥ DEPTH−1):
  - Combinational from registered count.
  - This leaves one free slot to absorb the instruction fetch may have in flight when it first sees hold.
  - hold does not depend on in_valid or out_ready.
- flush=1 (and rst=0) at an edge:
  - count=0, wr_ptr=0, rd_ptr=0.
  - flush takes priority over push and pop in the same cycle: in_instr is not stored, and the head counts as not consumed internally.
  - Consumer must ignore out_valid in a flush cycle.
  - overflow unchanged.
- Empty with out_ready=1: no pop, no pointer movement.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, out_ready=1 → count=0, out_valid=0, out_instr=0, out_pc=0, hold=0, overflow=0.
- Fill and hold (DEPTH=4), out_ready=0:
  - Push 0x11111111@0x00, 0x22222222@0x04, 0x33333333@0x08 on consecutive cycles.
  - After the 1st edge: out_valid=1, out_instr=0x11111111, out_pc=0x00.
  - After the 3rd edge: count=3, hold=1.
- Overflow:
  - With count=4 and out_ready=0, offer 0x55555555 → count stays 4, overflow=1, head still 0x11111111.
  - Next cycle, out_ready=1 and offer 0x66666666 → count stays 4, head becomes 0x22222222.
  - Draining then yields 0x22222222, 0x33333333, 0x44444444, 0x66666666.
- Streaming/wrap:
  - out_ready=1 constantly; push 10 instrs 0xA0..0xA9 at PCs 0x00..0x24 step 4.
  - Each appears exactly one cycle after its push, in order.
  - count never exceeds 1; pointers wrap twice; overflow=0.
- Flush priority:
  - With count=3, assert flush with in_valid=1 (0x77777777) and out_ready=1 → next cycle count=0, out_valid=0, hold=0.
  - A following push of 0x88888888 appears as the head; overflow unchanged.
- Reset mid-operation: with count=2 and overflow=1, pulse rst for 1 cycle → count=0, out_valid=0, overflow=0; the next push is accepted normally.
